// File: rtl/cdm16_seq_ctrl.sv
// cdm16_seq_ctrl: computes one 16x16 carry-disregard product.
// Four byte products go through a single shared 8x8 unit in the fixed
// order LL, HL, LH, HH. They are folded into four byte-wide accumulators
// whose adders drop their carries.
module cdm16_seq_ctrl #(
    parameter int         PP_LAT  = 0,
    parameter logic [1:0] SEL_LL  = 2'd0,
    parameter logic [1:0] SEL_MID = 2'd1,
    parameter logic [1:0] SEL_HH  = 2'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic        pp_valid,
    output logic [7:0]  pp_a,
    output logic [7:0]  pp_b,
    output logic [1:0]  pp_sel,
    input  logic [15:0] pp_r,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] R,
    output logic        busy
);

    localparam int CW = (PP_LAT > 0) ? $clog2(PP_LAT + 1) : 1;
    localparam logic [CW-1:0] LAT_LAST = CW'(PP_LAT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state;
    logic [1:0]    step;
    logic [CW-1:0] wait_cnt;
    logic [15:0]   a_reg;
    logic [15:0]   b_reg;
    logic [7:0]    r0;
    logic [7:0]    r1;
    logic [7:0]    r2;
    logic [7:0]    r3;

    // Handshake and status flags decode directly from the state register
    assign in_ready  = (state == S_IDLE);
    assign pp_valid  = (state == S_MUL);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign R         = {r3, r2, r1, r0};

    // Operand byte selection and approximation select for the current step
    always_comb begin
        pp_a   = a_reg[7:0];
        pp_b   = b_reg[7:0];
        pp_sel = SEL_LL;
        case (step)
            2'd0: begin
                pp_a   = a_reg[7:0];
                pp_b   = b_reg[7:0];
                pp_sel = SEL_LL;
            end
            2'd1: begin
                pp_a   = a_reg[15:8];
                pp_b   = b_reg[7:0];
                pp_sel = SEL_MID;
            end
            2'd2: begin
                pp_a   = a_reg[7:0];
                pp_b   = b_reg[15:8];
                pp_sel = SEL_MID;
            end
            default: begin
                pp_a   = a_reg[15:8];
                pp_b   = b_reg[15:8];
                pp_sel = SEL_HH;
            end
        endcase
    end

    // Sequencer: accept, step through the four products, hold the result until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            step     <= 2'd0;
            wait_cnt <= '0;
            a_reg    <= 16'h0;
            b_reg    <= 16'h0;
            r0       <= 8'h0;
            r1       <= 8'h0;
            r2       <= 8'h0;
            r3       <= 8'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_reg    <= A;
                        b_reg    <= B;
                        r0       <= 8'h0;
                        r1       <= 8'h0;
                        r2       <= 8'h0;
                        r3       <= 8'h0;
                        step     <= 2'd0;
                        wait_cnt <= '0;
                        state    <= S_MUL;
                    end
                end
                S_MUL: begin
                    if (wait_cnt == LAT_LAST) begin
                        wait_cnt <= '0;
                        case (step)
                            2'd0: begin
                                r0 <= r0 + pp_r[7:0];
                                r1 <= r1 + pp_r[15:8];
                            end
                            2'd1, 2'd2: begin
                                r1 <= r1 + pp_r[7:0];
                                r2 <= r2 + pp_r[15:8];
                            end
                            default: begin
                                r2 <= r2 + pp_r[7:0];
                                r3 <= r3 + pp_r[15:8];
                            end
                        endcase
                        if (step == 2'd3) begin
                            step  <= 2'd0;
                            state <= S_DONE;
                        end else begin
                            step <= step + 2'd1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdm16_seq_ctrl.sv
// tb_cdm16_seq_ctrl: directed bench for cdm16_seq_ctrl.
// One instance runs against a combinational 8x8 model (PP_LAT=0). A second
// instance runs against a model that returns its product two cycles late
// (PP_LAT=2).
module tb_cdm16_seq_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] a_in;
    logic [15:0] b_in;

    logic        in_valid;
    logic        in_ready;
    logic        pp_valid;
    logic [7:0]  pp_a;
    logic [7:0]  pp_b;
    logic [1:0]  pp_sel;
    logic [15:0] pp_r;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] r_out;
    logic        busy;

    logic        in_valid_l;
    logic        in_ready_l;
    logic        pp_valid_l;
    logic [7:0]  pp_a_l;
    logic [7:0]  pp_b_l;
    logic [1:0]  pp_sel_l;
    logic [15:0] pp_r_l;
    logic        out_valid_l;
    logic        out_ready_l;
    logic [31:0] r_out_l;
    logic        busy_l;

    logic [15:0] d1;
    logic [15:0] d2;

    int checks;
    int errors;

    logic [18:0] exp_pp [4];

    cdm16_seq_ctrl #(.PP_LAT(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(a_in), .B(b_in), .pp_valid(pp_valid), .pp_a(pp_a), .pp_b(pp_b),
        .pp_sel(pp_sel), .pp_r(pp_r), .out_valid(out_valid),
        .out_ready(out_ready), .R(r_out), .busy(busy)
    );

    cdm16_seq_ctrl #(.PP_LAT(2)) dut_lat (
        .clk(clk), .rst(rst), .in_valid(in_valid_l), .in_ready(in_ready_l),
        .A(a_in), .B(b_in), .pp_valid(pp_valid_l), .pp_a(pp_a_l), .pp_b(pp_b_l),
        .pp_sel(pp_sel_l), .pp_r(pp_r_l), .out_valid(out_valid_l),
        .out_ready(out_ready_l), .R(r_out_l), .busy(busy_l)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Exact 8x8 unit with no latency
    assign pp_r = {8'h0, pp_a} * {8'h0, pp_b};

    // Exact 8x8 unit whose product appears two cycles after its operands
    always @(posedge clk) begin
        d1 <= {8'h0, pp_a_l} * {8'h0, pp_b_l};
        d2 <= d1;
    end
    assign pp_r_l = d2;

    // Present one request to the zero-latency instance for exactly one edge
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
        a_in     = a;
        b_in     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        exp_pp[0]   = {1'b1, 2'd0, 8'h34, 8'h78};
        exp_pp[1]   = {1'b1, 2'd1, 8'h12, 8'h78};
        exp_pp[2]   = {1'b1, 2'd1, 8'h34, 8'h56};
        exp_pp[3]   = {1'b1, 2'd2, 8'h12, 8'h56};
        rst         = 1'b1;
        a_in        = 16'h0;
        b_in        = 16'h0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        in_valid_l  = 1'b0;
        out_ready_l = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_pp_valid", pp_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_R", r_out, 0);
        checkOutput("rst_lat_in_ready", in_ready_l, 1);

        $display("[TB] 00FF x 00FF, latency");
        out_ready = 1'b1;
        applyStimulus(16'h00FF, 16'h00FF);
        checkOutput("s1_busy", busy, 1);
        checkOutput("s1_in_ready", in_ready, 0);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            checkOutput("s1_out_valid", out_valid, (i == 4) ? 1 : 0);
        end
        checkOutput("s1_R", r_out, 32'h0000FE01);
        @(posedge clk);
        #1;
        checkOutput("s1_back_idle", in_ready, 1);
        checkOutput("s1_out_valid_low", out_valid, 0);
        checkOutput("s1_R_hold", r_out, 32'h0000FE01);

        $display("[TB] FFFF x FFFF carry-disregard");
        applyStimulus(16'hFFFF, 16'hFFFF);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("s2_out_valid", out_valid, 1);
        checkOutput("s2_R", r_out, 32'hFEFD0001);
        @(posedge clk);
        #1;

        $display("[TB] pp sequence 1234 x 5678");
        checkOutput("s3_pp_idle", pp_valid, 0);
        applyStimulus(16'h1234, 16'h5678);
        for (int i = 0; i < 4; i++) begin
            checkOutput("s3_pp_step", {pp_valid, pp_sel, pp_a, pp_b}, exp_pp[i]);
            @(posedge clk);
            #1;
        end
        checkOutput("s3_pp_after", pp_valid, 0);
        checkOutput("s3_out_valid", out_valid, 1);
        checkOutput("s3_R", r_out, 32'h06250060);
        @(posedge clk);
        #1;

        $display("[TB] backpressure in DONE");
        out_ready = 1'b0;
        applyStimulus(16'h0003, 16'h0005);
        repeat (4) @(posedge clk);
        #1;
        in_valid = 1'b1;
        a_in     = 16'hFFFF;
        b_in     = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            checkOutput("s4_out_valid", out_valid, 1);
            checkOutput("s4_R", r_out, 32'h0000000F);
            checkOutput("s4_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        checkOutput("s4_still_done", out_valid, 1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("s4_idle", in_ready, 1);
        checkOutput("s4_out_valid_low", out_valid, 0);
        checkOutput("s4_R_hold", r_out, 32'h0000000F);

        $display("[TB] PP_LAT=2 instance");
        a_in       = 16'h1234;
        b_in       = 16'h5678;
        in_valid_l = 1'b1;
        @(posedge clk);
        #1;
        in_valid_l = 1'b0;
        for (int i = 0; i < 12; i++) begin
            checkOutput("s5_pp_step", {pp_valid_l, pp_sel_l, pp_a_l, pp_b_l}, exp_pp[i / 3]);
            checkOutput("s5_out_valid_early", out_valid_l, 0);
            @(posedge clk);
            #1;
        end
        checkOutput("s5_out_valid", out_valid_l, 1);
        checkOutput("s5_pp_after", pp_valid_l, 0);
        checkOutput("s5_R", r_out_l, 32'h06250060);
        out_ready_l = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("s5_idle", in_ready_l, 1);

        $display("[TB] reset during step 2");
        out_ready = 1'b1;
        applyStimulus(16'hFFFF, 16'hFFFF);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("s6_in_step2", {pp_valid, pp_sel, pp_a, pp_b}, {1'b1, 2'd1, 8'hFF, 8'hFF});
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("s6_in_ready", in_ready, 1);
        checkOutput("s6_busy", busy, 0);
        checkOutput("s6_R", r_out, 0);
        checkOutput("s6_out_valid", out_valid, 0);
        checkOutput("s6_pp_valid", pp_valid, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checkOutput("s6_no_out_valid", out_valid, 0);
        end
        applyStimulus(16'h00FF, 16'h00FF);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("s6_next_out_valid", out_valid, 1);
        checkOutput("s6_next_R", r_out, 32'h0000FE01);
        @(posedge clk);
        #1;
        checkOutput("s6_next_idle", in_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
